// File: rtl/line_sync_pkg.sv
// Shared types and constants for the line aligner.
//   rd_state_t        read-side FSM state encoding
//   BLANK_Y/BLANK_C   luma/chroma words emitted when there is no stored pixel
//   fall_edge/rise_edge  one-cycle edge detect from a registered and a live level
package line_sync_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PLAY   = 2'd1,
        PAD    = 2'd2,
        BYPASS = 2'd3
    } rd_state_t;

    localparam logic [9:0] BLANK_Y = 10'h040;
    localparam logic [9:0] BLANK_C = 10'h200;

    function automatic logic fall_edge(input logic prev, input logic cur);
        return prev & ~cur;
    endfunction

    function automatic logic rise_edge(input logic prev, input logic cur);
        return ~prev & cur;
    endfunction

endpackage

// File: rtl/line_bank_ram.sv
// Simple dual-port line storage with a registered read (one cycle of latency).
// The address is {bank, pixel pointer}, so each bank owns 2**PTR_W words;
// only the first MAX_ACTIVE words of each bank are ever written.
//   clk    in   clock
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address, sampled every cycle
//   rdata  out  read data, valid one cycle after raddr
module line_bank_ram #(
    parameter int DATA_W = 20,
    parameter int ADDR_W = 13
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/line_align_buffer.sv
// Multi-line aligner: stores each active input line into one of NUM_LINES banks
// and replays the oldest complete line on the next active period of ref_hvf.
// data_out/hvf_out trail ref_hvf by two cycles (RAM read + output register).
// Build option: define LINE_STATS_EN to enable the saturating stat_* counters;
// otherwise the stat_* ports are tied to zero.
//   clk, reset     clock and synchronous active-high reset
//   data_hblank    input blanking (1 = blank), data_in input pixel
//   ref_hvf        reference {F,V,H}, bit0 = hblank
//   data_out       aligned pixel, hvf_out ref_hvf delayed to match
//   active_count   length of the last committed input line
//   bypass         current ref line passes data_in through
//   overflow       pulse: input line truncated or dropped
//   underrun       pulse: first padded pixel while ref still active
//   stat_lines/stat_drops/stat_unders  event counters
//
// Read FSM
//   state  | meaning
//   IDLE   | waiting for ref active start
//   PLAY   | reading stored line from rd_bank
//   PAD    | stored line exhausted, emitting blank words
//   BYPASS | no stored line, passing data_in through
module line_align_buffer
    import line_sync_pkg::*;
#(
    parameter int DATA_W     = 20,
    parameter int MAX_ACTIVE = 1920,
    parameter int NUM_LINES  = 2,
    parameter int PTR_W      = 12,
    parameter logic [DATA_W-1:0] BLANK_VALUE = DATA_W'({BLANK_C, BLANK_Y})
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              data_hblank,
    input  logic [DATA_W-1:0] data_in,
    input  logic [2:0]        ref_hvf,
    output logic [DATA_W-1:0] data_out,
    output logic [2:0]        hvf_out,
    output logic [PTR_W-1:0]  active_count,
    output logic              bypass,
    output logic              overflow,
    output logic              underrun,
    output logic [15:0]       stat_lines,
    output logic [15:0]       stat_drops,
    output logic [15:0]       stat_unders
);

    localparam int BANK_W = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
    localparam logic [1:0] SEL_BLANK = 2'd0;
    localparam logic [1:0] SEL_RAM   = 2'd1;
    localparam logic [1:0] SEL_BYP   = 2'd2;

    function automatic logic [BANK_W-1:0] next_bank(input logic [BANK_W-1:0] b);
        return (b == BANK_W'(NUM_LINES - 1)) ? '0 : b + 1'b1;
    endfunction

    logic [NUM_LINES-1:0] valid;
    logic [PTR_W-1:0]     len [NUM_LINES];
    logic [BANK_W-1:0]    wr_bank, rd_bank;
    logic [PTR_W-1:0]     wr_ptr, rd_ptr, rd_ptr_nx, rd_addr_ptr;
    logic                 hblank_d, drop_line, trunc_seen, ref_d, pad_first, pad_first_nx;
    rd_state_t            state, state_nx;
    logic [1:0]           sel_nx, sel_q;
    logic                 bypass_nx, release_bank, underrun_nx;
    logic [2:0]           hvf_q;
    logic [DATA_W-1:0]    din_q, ram_q;

    // ---------------- write side ----------------
    logic line_start, line_end, start_drop, dropping, wr_full, wr_en, trunc_pulse, commit, overflow_nx;

    assign line_start  = fall_edge(hblank_d, data_hblank);
    assign line_end    = rise_edge(hblank_d, data_hblank);
    // A bank that is valid is either queued or being replayed; never overwrite it.
    assign start_drop  = line_start & valid[wr_bank];
    assign dropping    = line_start ? start_drop : drop_line;
    assign wr_full     = (wr_ptr == PTR_W'(MAX_ACTIVE));
    assign wr_en       = ~data_hblank & ~dropping & ~wr_full;
    assign trunc_pulse = ~data_hblank & ~dropping & wr_full & ~trunc_seen;
    assign commit      = line_end & ~drop_line & (wr_ptr != '0);
    assign overflow_nx = start_drop | trunc_pulse;

    // ---------------- read side ----------------
    logic ref_fall, ref_rise;
    assign ref_fall = fall_edge(ref_d, ref_hvf[0]);
    assign ref_rise = rise_edge(ref_d, ref_hvf[0]);

    always_comb begin
        state_nx     = state;
        rd_ptr_nx    = rd_ptr;
        rd_addr_ptr  = rd_ptr;
        sel_nx       = SEL_BLANK;
        bypass_nx    = bypass;
        release_bank = 1'b0;
        pad_first_nx = pad_first;
        underrun_nx  = 1'b0;
        if (ref_rise) begin
            state_nx     = IDLE;
            release_bank = (state == PLAY) || (state == PAD);
            pad_first_nx = 1'b0;
        end else if (!ref_hvf[0]) begin
            case (state)
                IDLE: begin
                    // valid is the registered value, so a line committed on this
                    // same cycle is not yet eligible.
                    if (ref_fall) begin
                        if (valid[rd_bank]) begin
                            sel_nx      = SEL_RAM;
                            rd_addr_ptr = '0;
                            rd_ptr_nx   = PTR_W'(1);
                            bypass_nx   = 1'b0;
                            if (len[rd_bank] == PTR_W'(1)) begin
                                state_nx     = PAD;
                                pad_first_nx = 1'b1;
                            end else begin
                                state_nx = PLAY;
                            end
                        end else begin
                            state_nx  = BYPASS;
                            sel_nx    = SEL_BYP;
                            bypass_nx = 1'b1;
                        end
                    end
                end
                PLAY: begin
                    sel_nx    = SEL_RAM;
                    rd_ptr_nx = rd_ptr + 1'b1;
                    if (rd_ptr == len[rd_bank] - PTR_W'(1)) begin
                        state_nx     = PAD;
                        pad_first_nx = 1'b1;
                    end
                end
                PAD: begin
                    underrun_nx  = pad_first;
                    pad_first_nx = 1'b0;
                end
                BYPASS:  sel_nx = SEL_BYP;
                default: state_nx = IDLE;
            endcase
        end
    end

    line_bank_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (BANK_W + PTR_W)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr ({wr_bank, wr_ptr}),
        .wdata (data_in),
        .raddr ({rd_bank, rd_addr_ptr}),
        .rdata (ram_q)
    );

    always_ff @(posedge clk) begin
        if (commit) begin
            len[wr_bank] <= wr_ptr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // Come out of reset as if mid-line so a partially seen line is discarded.
            hblank_d     <= 1'b0;
            drop_line    <= 1'b1;
            trunc_seen   <= 1'b0;
            wr_ptr       <= '0;
            wr_bank      <= '0;
            valid        <= '0;
            active_count <= '0;
            overflow     <= 1'b0;
            ref_d        <= 1'b0;
            state        <= IDLE;
            rd_bank      <= '0;
            rd_ptr       <= '0;
            pad_first    <= 1'b0;
            bypass       <= 1'b0;
            underrun     <= 1'b0;
            sel_q        <= SEL_BLANK;
            hvf_q        <= '0;
            din_q        <= '0;
            data_out     <= '0;
            hvf_out      <= '0;
        end else begin
            hblank_d <= data_hblank;
            if (line_start) begin
                drop_line <= start_drop;
            end else if (line_end) begin
                drop_line <= 1'b0;
            end
            if (line_end) begin
                wr_ptr     <= '0;
                trunc_seen <= 1'b0;
            end else begin
                if (wr_en) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (trunc_pulse) begin
                    trunc_seen <= 1'b1;
                end
            end
            if (commit) begin
                active_count <= wr_ptr;
                wr_bank      <= next_bank(wr_bank);
            end
            for (int b = 0; b < NUM_LINES; b++) begin
                if (commit && wr_bank == BANK_W'(b)) begin
                    valid[b] <= 1'b1;
                end else if (release_bank && rd_bank == BANK_W'(b)) begin
                    valid[b] <= 1'b0;
                end
            end
            overflow <= overflow_nx;

            ref_d     <= ref_hvf[0];
            state     <= state_nx;
            rd_ptr    <= rd_ptr_nx;
            pad_first <= pad_first_nx;
            bypass    <= bypass_nx;
            underrun  <= underrun_nx;
            if (release_bank) begin
                rd_bank <= next_bank(rd_bank);
            end

            sel_q   <= sel_nx;
            hvf_q   <= ref_hvf;
            din_q   <= data_in;
            hvf_out <= hvf_q;
            case (sel_q)
                SEL_RAM: data_out <= ram_q;
                SEL_BYP: data_out <= din_q;
                default: data_out <= BLANK_VALUE;
            endcase
        end
    end

`ifdef LINE_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_lines  <= '0;
            stat_drops  <= '0;
            stat_unders <= '0;
        end else begin
            if (commit && stat_lines != 16'hFFFF) begin
                stat_lines <= stat_lines + 1'b1;
            end
            if (overflow_nx && stat_drops != 16'hFFFF) begin
                stat_drops <= stat_drops + 1'b1;
            end
            if (underrun_nx && stat_unders != 16'hFFFF) begin
                stat_unders <= stat_unders + 1'b1;
            end
        end
    end
`else
    assign stat_lines  = '0;
    assign stat_drops  = '0;
    assign stat_unders = '0;
`endif

endmodule
